// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT polynomial datapath blocks.
package ntt_pkg;

    // Width of the multiplier-latency counter; covers MULT_PIPELINE 0..15.
    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM,
        DONE
    } stream_state_t;

endpackage

// File: rtl/ntt_poly_stream_out.sv
// Captures a full polynomial from the pointwise multiplier once its latency
// has elapsed, then streams it out one coefficient per handshake.
module ntt_poly_stream_out
    import ntt_pkg::*;
#(
    parameter int unsigned N             = 256,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MULT_PIPELINE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*WIDTH-1:0]     poly_c_flat,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last,
    output logic                   done
);

    localparam int unsigned         IW       = $clog2(N);
    localparam logic [LAT_CNT_W-1:0] LAT     = LAT_CNT_W'(MULT_PIPELINE);
    localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);

    stream_state_t          state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q;
    logic [IW-1:0]          idx_q;
    logic [WIDTH-1:0]       buf_q [N];
    logic                   capture;
    logic                   hs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode, capture strobe and status outputs.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        busy      = (state_q != IDLE);
        out_valid = (state_q == STREAM);
        out_last  = out_valid && (idx_q == LAST_IDX);
        done      = (state_q == DONE);
        hs        = out_valid && out_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (LAT == '0) begin
                        capture = 1'b1;
                        state_d = STREAM;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter holds the cycles still owed; the last one is the capture edge.
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs && out_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latency counter and stream index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            if (state_q == IDLE && start) cnt_q <= LAT;
            else if (state_q == WAIT)     cnt_q <= cnt_q - LAT_CNT_W'(1);
            if (hs) idx_q <= out_last ? '0 : idx_q + IW'(1);
        end
    end

    // Coefficient buffer; loaded only on the capture edge, never reset.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int unsigned i = 0; i < N; i++) begin
                buf_q[i] <= poly_c_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_index = idx_q;
    assign out_data  = out_valid ? buf_q[idx_q] : '0;

endmodule

// File: tb/tb_ntt_poly_stream_out.sv
// Self-checking bench for ntt_poly_stream_out (N=8, WIDTH=32, latency 3 and 0).
module tb_ntt_poly_stream_out;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int MP = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0, start0 = 1'b0;
    logic           ready = 1'b0, ready0 = 1'b0;
    logic [N*W-1:0] poly = '0;

    logic           busy, valid, last, done;
    logic [W-1:0]   data;
    logic [2:0]     idx;
    logic           busy0, valid0, last0, done0;
    logic [W-1:0]   data0;
    logic [2:0]     idx0;

    logic [W-1:0]   coef [N];
    int unsigned    n_cmp = 0;
    int unsigned    n_err = 0;

    ntt_poly_stream_out #(.N(N), .WIDTH(W), .MULT_PIPELINE(MP)) dut (
        .clk(clk), .rst(rst), .start(start), .poly_c_flat(poly),
        .busy(busy), .out_valid(valid), .out_ready(ready), .out_data(data),
        .out_index(idx), .out_last(last), .done(done)
    );

    ntt_poly_stream_out #(.N(N), .WIDTH(W), .MULT_PIPELINE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .poly_c_flat(poly),
        .busy(busy0), .out_valid(valid0), .out_ready(ready0), .out_data(data0),
        .out_index(idx0), .out_last(last0), .done(done0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_coefs(input bit rnd);
        for (int i = 0; i < N; i++) begin
            coef[i] = rnd ? $urandom : W'(i * 1000 + 7);
            poly[i*W +: W] = coef[i];
        end
    endtask

    // Outputs are sampled at the falling edge; inputs changed right after
    // sampling take effect at the following rising edge.
    task automatic test_reset;
        rst = 1'b1; start = 1'b1; start0 = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b exp 0", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", valid); end
        n_cmp++; if (last  !== 1'b0) begin n_err++; $display("FAIL rst_last got %0b exp 0", last); end
        n_cmp++; if (done  !== 1'b0) begin n_err++; $display("FAIL rst_done got %0b exp 0", done); end
        n_cmp++; if (idx   !== 3'd0) begin n_err++; $display("FAIL rst_index got %0d exp 0", idx); end
        n_cmp++; if (data  !== '0)   begin n_err++; $display("FAIL rst_data got %h exp 0", data); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy0 got %0b exp 0", busy0); end
        rst = 1'b0; start = 1'b0; start0 = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored got busy %0b exp 0", busy); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored0 got busy %0b exp 0", busy0); end
    endtask

    // Exact cycle timing with continuous ready: start in cycle 0.
    task automatic test_basic;
        bit exp_v;
        int j;
        load_coefs(0);
        ready = 1'b1;
        for (int k = 0; k <= MP + N + 3; k++) begin
            @(negedge clk);
            exp_v = (k >= MP + 1) && (k <= MP + N);
            j = k - MP - 1;
            n_cmp++; if (valid !== exp_v) begin n_err++; $display("FAIL basic_valid k=%0d got %0b exp %0b", k, valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (data !== coef[j]) begin n_err++; $display("FAIL basic_data k=%0d got %0d exp %0d", k, data, coef[j]); end
                n_cmp++; if (idx !== 3'(j)) begin n_err++; $display("FAIL basic_index k=%0d got %0d exp %0d", k, idx, j); end
                n_cmp++; if (last !== (j == N - 1)) begin n_err++; $display("FAIL basic_last k=%0d got %0b exp %0b", k, last, (j == N - 1)); end
            end
            n_cmp++; if (done !== (k == MP + N + 1)) begin n_err++; $display("FAIL basic_done k=%0d got %0b exp %0b", k, done, (k == MP + N + 1)); end
            n_cmp++; if (busy !== (k >= 1 && k <= MP + N + 1)) begin n_err++; $display("FAIL basic_busy k=%0d got %0b exp %0b", k, busy, (k >= 1 && k <= MP + N + 1)); end
            start = (k == 0);
        end
    endtask

    // Multiplier bus overwritten after the capture edge must not leak through.
    task automatic test_capture;
        int j;
        load_coefs(1);
        ready = 1'b1;
        for (int k = 0; k <= MP + N + 3; k++) begin
            @(negedge clk);
            j = k - MP - 1;
            if (valid) begin
                if (j < 0 || j >= N) begin
                    n_cmp++; n_err++; $display("FAIL capture_valid k=%0d got 1 exp 0", k);
                end else begin
                    n_cmp++; if (data !== coef[j]) begin n_err++; $display("FAIL capture_data k=%0d got %h exp %h", k, data, coef[j]); end
                end
            end
            start = (k == 0);
            if (k == MP + 1) poly = '1;
        end
    endtask

    // Ready pattern 1,0,0,1: stalls hold outputs, no duplicates or skips.
    task automatic test_stall;
        logic [3:0] pat = 4'b1001;
        int h = 0, dn = 0;
        bit pv = 0, pr = 0;
        logic [W-1:0] pd = '0;
        logic [2:0] pi = '0;
        load_coefs(1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid) begin
                if (h >= N) begin
                    n_cmp++; n_err++; $display("FAIL stall_overrun k=%0d got handshakes %0d exp %0d", k, h, N);
                end else begin
                    n_cmp++; if (data !== coef[h]) begin n_err++; $display("FAIL stall_data k=%0d got %h exp %h", k, data, coef[h]); end
                    n_cmp++; if (idx !== 3'(h)) begin n_err++; $display("FAIL stall_index k=%0d got %0d exp %0d", k, idx, h); end
                    n_cmp++; if (last !== (h == N - 1)) begin n_err++; $display("FAIL stall_last k=%0d got %0b exp %0b", k, last, (h == N - 1)); end
                end
                if (pv && !pr) begin
                    n_cmp++; if (data !== pd || idx !== pi) begin n_err++; $display("FAIL stall_hold k=%0d got %h/%0d exp %h/%0d", k, data, idx, pd, pi); end
                end
            end
            if (done) dn++;
            start = (k == 0);
            ready = pat[k % 4];
            pv = valid; pr = ready; pd = data; pi = idx;
            if (valid && ready) h++;
        end
        n_cmp++; if (h != N) begin n_err++; $display("FAIL stall_handshakes got %0d exp %0d", h, N); end
        n_cmp++; if (dn != 1) begin n_err++; $display("FAIL stall_done_count got %0d exp 1", dn); end
        ready = 1'b1;
    endtask

    // start pulses in WAIT, mid-stream and in the done cycle are all ignored.
    task automatic test_restart_ignored;
        int h = 0, dn = 0;
        bit pdone = 0;
        load_coefs(1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) begin
                if (h >= N) begin
                    n_cmp++; n_err++; $display("FAIL restart_overrun k=%0d got handshakes %0d exp %0d", k, h, N);
                end else begin
                    n_cmp++; if (data !== coef[h] || idx !== 3'(h)) begin n_err++; $display("FAIL restart_data k=%0d got %h/%0d exp %h/%0d", k, data, idx, coef[h], h); end
                end
            end
            if (pdone) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_after_done got busy %0b exp 0", busy); end
            end
            if (done) dn++;
            ready = ($urandom_range(0, 3) != 0);
            start = (k == 0) || (k == 2) || (valid && idx == 3'd4) || done;
            pdone = done;
            if (valid && ready) h++;
        end
        n_cmp++; if (h != N) begin n_err++; $display("FAIL restart_handshakes got %0d exp %0d", h, N); end
        n_cmp++; if (dn != 1) begin n_err++; $display("FAIL restart_done_count got %0d exp 1", dn); end
        ready = 1'b1;
    endtask

    // Reset at index 5 aborts without done; a fresh start streams from index 0.
    task automatic test_reset_abort;
        int dn = 0, j;
        bit armed = 0, aborted = 0, exp_v;
        load_coefs(1);
        ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = (k == 0);
            if (armed) begin
                n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %0b exp 0", valid); end
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %0b exp 0", busy); end
                n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL abort_index got %0d exp 0", idx); end
                rst = 1'b0; armed = 0; aborted = 1;
            end else if (aborted) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle k=%0d got busy %0b exp 0", k, busy); end
            end
            if (done) dn++;
            if (!aborted && !armed && valid && idx == 3'd5) begin
                rst = 1'b1; start = 1'b1; armed = 1;
            end
        end
        n_cmp++; if (!aborted) begin n_err++; $display("FAIL abort_reached got 0 exp 1"); end
        n_cmp++; if (dn != 0) begin n_err++; $display("FAIL abort_done_count got %0d exp 0", dn); end
        rst = 1'b0; start = 1'b0;
        load_coefs(1);
        dn = 0;
        for (int k = 0; k <= MP + N + 2; k++) begin
            @(negedge clk);
            exp_v = (k >= MP + 1) && (k <= MP + N);
            j = k - MP - 1;
            n_cmp++; if (valid !== exp_v) begin n_err++; $display("FAIL rerun_valid k=%0d got %0b exp %0b", k, valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (data !== coef[j] || idx !== 3'(j)) begin n_err++; $display("FAIL rerun_data k=%0d got %h/%0d exp %h/%0d", k, data, idx, coef[j], j); end
            end
            if (done) dn++;
            start = (k == 0);
        end
        n_cmp++; if (dn != 1) begin n_err++; $display("FAIL rerun_done_count got %0d exp 1", dn); end
    endtask

    // Zero multiplier latency: capture at the start edge, valid the next cycle.
    task automatic test_zero_latency;
        bit exp_v;
        int j;
        load_coefs(1);
        ready0 = 1'b1;
        for (int k = 0; k <= N + 3; k++) begin
            @(negedge clk);
            exp_v = (k >= 1) && (k <= N);
            j = k - 1;
            n_cmp++; if (valid0 !== exp_v) begin n_err++; $display("FAIL zl_valid k=%0d got %0b exp %0b", k, valid0, exp_v); end
            if (exp_v) begin
                n_cmp++; if (data0 !== coef[j] || idx0 !== 3'(j)) begin n_err++; $display("FAIL zl_data k=%0d got %h/%0d exp %h/%0d", k, data0, idx0, coef[j], j); end
                n_cmp++; if (last0 !== (j == N - 1)) begin n_err++; $display("FAIL zl_last k=%0d got %0b exp %0b", k, last0, (j == N - 1)); end
            end
            n_cmp++; if (done0 !== (k == N + 1)) begin n_err++; $display("FAIL zl_done k=%0d got %0b exp %0b", k, done0, (k == N + 1)); end
            start0 = (k == 0);
        end
        ready0 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_capture;
        test_stall;
        test_restart_ignored;
        test_reset_abort;
        test_zero_latency;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
